keypad_matrix_emulator: RTL and testbench
=========================================

# keypad_matrix_emulator

- Emulates a 4x4 hex keypad matrix for loopback testing of the keypad scanner on silicon and in simulation.
- Accepts a key code from a host over a valid/ready handshake, then acts as the physical key: it drives the row lines in response to the scanner's column drive.
- Each press follows a timed sequence: press contact bounce, hold, release bounce, then an inter-key gap.
- It sits opposite the scanner: its `row`/`s_row` outputs feed the scanner's inputs, and the scanner's `col` output feeds back into it.

## Interface

Parameters:
- `HOLD_CYCLES`, default 20: cycles the contact is held solidly closed.
- `BOUNCE_CYCLES`, default 8: length of each bounce phase (press and release); 0 skips both bounce phases.
- `BOUNCE_PERIOD`, default 2: cycles per contact level while bouncing; must be ≥1.
- `GAP_CYCLES`, default 5: cycles of open contact after release, before the next key is accepted; must be ≥1.

Ports:
- `clk` in, 1: single system clock.
- `rst` in, 1: reset, asynchronous and active-low.
- `key_code` in, 4: key to press; same encoding as the scanner's `code` output.
- `key_valid` in, 1: host request.
- `key_ready` out, 1: emulator can accept a request.
- `col` in, 4: column drive from the scanner.
- `row` out, 4: emulated row sense, one-hot or zero.
- `s_row` out, 1: "some key is closed" indication, independent of `col`.
- `busy` out, 1: a press sequence is in progress.
- `done` out, 1: one-cycle pulse marking the end of a sequence.

## Operation

Key map (code → row, col):
- Codes 1, 2, 3, A → row 0, cols 0, 1, 2, 3.
- Codes 4, 5, 6, B → row 1, cols 0, 1, 2, 3.
- Codes 7, 8, 9, C → row 2, cols 0, 1, 2, 3.
- Row 3: code E → `*` at col 0; code 0 → col 1; code F → `#` at col 2; code D → col 3.

Handshake:
- A transfer happens when `key_valid` and `key_ready` are both high at a rising `clk`.
- `key_code` is latched on that edge.
- `key_ready` = 1 only in IDLE.

State machine (IDLE → PBOUNCE → HOLD → RBOUNCE → GAP → IDLE):
- IDLE → PBOUNCE on transfer, or → HOLD directly when `BOUNCE_CYCLES` = 0.
- PBOUNCE: contact starts closed and toggles every `BOUNCE_PERIOD` cycles; lasts `BOUNCE_CYCLES` cycles, then → HOLD.
- HOLD: contact = 1 for `HOLD_CYCLES` cycles, then → RBOUNCE, or → GAP when `BOUNCE_CYCLES` = 0.
- RBOUNCE: contact starts open and toggles every `BOUNCE_PERIOD` cycles; lasts `BOUNCE_CYCLES` cycles, then → GAP.
- GAP: contact = 0 for `GAP_CYCLES` cycles, then → IDLE.

Outputs:
- `row` = row_onehot(latched key) when contact = 1 and `col` has the key's column bit set; otherwise `row` = 0. Multi-bit `col` values such as 4'hF also match when the key's bit is set.
- `s_row` = contact register.
- `busy` = (state ≠ IDLE).
- `done` pulses high in the first IDLE cycle after GAP.

Arithmetic:
- One shared down-counter, width $clog2(max(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES) + 1). It is reloaded on every state entry.
- One bounce-period counter, width $clog2(BOUNCE_PERIOD + 1). The contact toggles when it expires.

Boundary conditions:
- `key_valid` outside IDLE is ignored; no queueing.
- Acceptance is allowed in the same cycle `done` is high.
- `key_code` changes after acceptance have no effect.
- Reset asserted mid-sequence: state → IDLE and contact → 0 immediately, asynchronously. No `done` pulse is produced.

## Timing

Reset values:
- `row` = 0, `s_row` = 0, `busy` = 0, `done` = 0, `key_ready` = 1.
- Contact register = 0, latched code = 0.

Latency and paths:
- Transfer at edge t0: the first PBOUNCE cycle is t0+1, and contact is high from t0+1.
- IDLE is re-entered at t0 + 1 + 2·BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES; defaults give t0+42.
- `col` → `row` is combinational, zero-cycle, so a one-cycle-per-column scan sees the row in the same cycle.
- All other outputs are registered.

## Structure

- Package `keypad_pkg` holds:
  - key code localparams: KEY_0…KEY_9, KEY_A…KEY_D, KEY_STAR = 4'hE, KEY_HASH = 4'hF;
  - the emulator state enum `kp_emu_state_t`;
  - the function `key_to_rc(code)`, which returns the row and column one-hot pair.
- The package is shared with the scanner and its testbench.
- Sub-module: `kp_phase_counter`, a loadable down-counter with a `zero` flag, instantiated twice (phase counter and bounce-period counter).

## Test plan

Directed scenarios, with default parameters unless stated:
1. Reset: hold `rst` = 0 for 3 cycles, `col` = 4'hF → `row` = 0, `s_row` = 0, `key_ready` = 1, `busy` = 0.
2. Press code 5, `col` = 4'b0010 held:
   - `row` = 4'b0010 at t0+1–2 and t0+5–6 (PBOUNCE closed levels);
   - `row` = 4'b0010 continuously at t0+9–28 (HOLD);
   - `done` pulses at t0+42.
3. Loopback with the scanner for codes 0–9 and A–D → each scanner `code` equals the key sent, exactly one accepted digit per press after debounce.
4. Column mismatch: key A with `col` = 4'b0001 → `row` = 0 throughout while `s_row` = 1 in HOLD.
5. `key_valid` held high during `busy`, second code 7 → ignored. Code 7 is accepted only at the `done` cycle, and the first row output is 4'b0100 on `col` = 4'b0001.
6. With `BOUNCE_CYCLES` = 0, press code F → `row` = 4'b1000 on `col` = 4'b0100 at t0+1–20. Assert `rst` at t0+10 → `row` = 0 and `s_row` = 0 at once, and no `done` pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, emulator states and the code -> (row, col) map.
// Used by the matrix emulator, the scanner and their benches.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PBOUNCE,
    ST_HOLD,
    ST_RBOUNCE,
    ST_GAP
  } kp_emu_state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_rc_t;

  function automatic key_rc_t key_to_rc(input logic [3:0] code);
    key_rc_t    rc;
    logic [1:0] ri;
    logic [1:0] ci;
    ri = 2'd0;
    ci = 2'd0;
    case (code)
      KEY_1:    begin ri = 2'd0; ci = 2'd0; end
      KEY_2:    begin ri = 2'd0; ci = 2'd1; end
      KEY_3:    begin ri = 2'd0; ci = 2'd2; end
      KEY_A:    begin ri = 2'd0; ci = 2'd3; end
      KEY_4:    begin ri = 2'd1; ci = 2'd0; end
      KEY_5:    begin ri = 2'd1; ci = 2'd1; end
      KEY_6:    begin ri = 2'd1; ci = 2'd2; end
      KEY_B:    begin ri = 2'd1; ci = 2'd3; end
      KEY_7:    begin ri = 2'd2; ci = 2'd0; end
      KEY_8:    begin ri = 2'd2; ci = 2'd1; end
      KEY_9:    begin ri = 2'd2; ci = 2'd2; end
      KEY_C:    begin ri = 2'd2; ci = 2'd3; end
      KEY_STAR: begin ri = 2'd3; ci = 2'd0; end
      KEY_0:    begin ri = 2'd3; ci = 2'd1; end
      KEY_HASH: begin ri = 2'd3; ci = 2'd2; end
      default:  begin ri = 2'd3; ci = 2'd3; end
    endcase
    rc.row = 4'b0001 << ri;
    rc.col = 4'b0001 << ci;
    return rc;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Host-side key request handshake for the keypad matrix emulator.
interface keypad_matrix_emulator_if;
  import keypad_pkg::*;

  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/kp_phase_counter.sv
// Loadable down-counter that holds at zero; zero_o flags the last cycle of a timed interval.
module kp_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 matrix: accepts a code from the host, then plays a timed
// bounce / hold / bounce / gap contact sequence and answers the scanner's column drive.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 20,
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int GAP_CYCLES    = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  keypad_matrix_emulator_if.slave         host_if,
  input  logic [3:0]                      col_i,
  output logic [3:0]                      row_o,
  output logic                            s_row_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int MAXC = max3(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES);
  localparam int PW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam int BW   = $clog2(BOUNCE_PERIOD + 1);

  // Counters are loaded with N-1 so the zero flag marks the final cycle of an N-cycle phase.
  localparam logic [PW-1:0] LD_HOLD   = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] LD_BOUNCE = PW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [PW-1:0] LD_GAP    = PW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LD_PER    = BW'(BOUNCE_PERIOD - 1);
  localparam bit            NO_BOUNCE = (BOUNCE_CYCLES == 0);

  kp_emu_state_t state_q, state_d;
  logic          contact_q, contact_d;
  logic [3:0]    code_q, code_d;
  logic          done_q, done_d;

  logic          ph_load;
  logic [PW-1:0] ph_val;
  logic          ph_zero;
  logic          bp_load;
  logic          bp_zero;
  key_rc_t       rc;

  kp_phase_counter #(.WIDTH(PW)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .zero_o     (ph_zero)
  );

  kp_phase_counter #(.WIDTH(BW)) u_period_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bp_load),
    .load_val_i (LD_PER),
    .zero_o     (bp_zero)
  );

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    code_d    = code_q;
    done_d    = 1'b0;
    ph_load   = 1'b0;
    ph_val    = '0;
    bp_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host_if.key_valid) begin
          code_d    = host_if.key_code;
          contact_d = 1'b1;
          ph_load   = 1'b1;
          if (NO_BOUNCE) begin
            state_d = ST_HOLD;
            ph_val  = LD_HOLD;
          end else begin
            state_d = ST_PBOUNCE;
            ph_val  = LD_BOUNCE;
            bp_load = 1'b1;
          end
        end
      end
      ST_PBOUNCE: begin
        if (ph_zero) begin
          state_d   = ST_HOLD;
          contact_d = 1'b1;
          ph_load   = 1'b1;
          ph_val    = LD_HOLD;
        end else if (bp_zero) begin
          contact_d = ~contact_q;
          bp_load   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_zero) begin
          contact_d = 1'b0;
          ph_load   = 1'b1;
          if (NO_BOUNCE) begin
            state_d = ST_GAP;
            ph_val  = LD_GAP;
          end else begin
            state_d = ST_RBOUNCE;
            ph_val  = LD_BOUNCE;
            bp_load = 1'b1;
          end
        end
      end
      ST_RBOUNCE: begin
        if (ph_zero) begin
          state_d   = ST_GAP;
          contact_d = 1'b0;
          ph_load   = 1'b1;
          ph_val    = LD_GAP;
        end else if (bp_zero) begin
          contact_d = ~contact_q;
          bp_load   = 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      contact_q <= 1'b0;
      code_q    <= 4'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      code_q    <= code_d;
      done_q    <= done_d;
    end
  end

  // Column-to-row path is deliberately combinational so a one-cycle-per-column scan sees it.
  assign rc                = key_to_rc(code_q);
  assign row_o             = (contact_q && ((col_i & rc.col) != 4'b0000)) ? rc.row : 4'b0000;
  assign s_row_o           = contact_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = done_q;
  assign host_if.key_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: default instance plus a no-bounce instance.
module tb_keypad_matrix_emulator;
  import keypad_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  keypad_matrix_emulator_if h1 ();
  keypad_matrix_emulator_if h2 ();

  logic [3:0] col1, row1, col2, row2;
  logic       s_row1, busy1, done1, s_row2, busy2, done2;

  logic [3:0] kmap [0:15];
  logic [3:0] codes [0:13];

  keypad_matrix_emulator dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .host_if (h1.slave),
    .col_i   (col1),
    .row_o   (row1),
    .s_row_o (s_row1),
    .busy_o  (busy1),
    .done_o  (done1)
  );

  keypad_matrix_emulator #(
    .HOLD_CYCLES   (20),
    .BOUNCE_CYCLES (0),
    .BOUNCE_PERIOD (2),
    .GAP_CYCLES    (5)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .host_if (h2.slave),
    .col_i   (col2),
    .row_o   (row2),
    .s_row_o (s_row2),
    .busy_o  (busy2),
    .done_o  (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_row;
    logic       closed;
    int         hits;
    int         fr;
    int         fc;
    total = 0;
    bad   = 0;
    kmap  = '{4'h1, 4'h2, 4'h3, 4'hA,
              4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC,
              4'hE, 4'h0, 4'hF, 4'hD};
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
              4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
    h1.key_code = 4'h0; h1.key_valid = 1'b0;
    h2.key_code = 4'h0; h2.key_valid = 1'b0;
    col1 = 4'hF; col2 = 4'h0;

    // 1: reset
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_row", {4'h0, row1}, 8'h00);
    chk("rst_srow", {7'h0, s_row1}, 8'h00);
    chk("rst_ready", {7'h0, h1.key_ready}, 8'h01);
    chk("rst_busy", {7'h0, busy1}, 8'h00);
    chk("rst_done", {7'h0, done1}, 8'h00);
    #3 rst_n = 1'b1;
    step();

    // 2: code 5 with col 0010, full timing
    col1 = 4'b0010;
    h1.key_code = 4'h5; h1.key_valid = 1'b1;
    step();
    h1.key_valid = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      closed = (k == 1 || k == 2 || k == 5 || k == 6 || (k >= 9 && k <= 28) ||
                k == 31 || k == 32 || k == 35 || k == 36);
      exp_row = closed ? 4'b0010 : 4'b0000;
      $display("press5 k=%0d row=%b srow=%b busy=%b done=%b", k, row1, s_row1, busy1, done1);
      chk($sformatf("p5_row_k%0d", k), {4'h0, row1}, {4'h0, exp_row});
      chk($sformatf("p5_srow_k%0d", k), {7'h0, s_row1}, {7'h0, closed});
      chk($sformatf("p5_busy_k%0d", k), {7'h0, busy1}, (k < 42) ? 8'h01 : 8'h00);
      chk($sformatf("p5_done_k%0d", k), {7'h0, done1}, (k == 42) ? 8'h01 : 8'h00);
      if (k < 42) step();
    end
    chk("p5_ready_end", {7'h0, h1.key_ready}, 8'h01);
    step();
    chk("p5_done_once", {7'h0, done1}, 8'h00);

    // 3: scan loopback for 0-9, A-D
    for (int i = 0; i < 14; i++) begin
      h1.key_code = codes[i]; h1.key_valid = 1'b1;
      step();
      h1.key_valid = 1'b0;
      repeat (14) step();
      hits = 0; fr = 0; fc = 0;
      for (int c = 0; c < 4; c++) begin
        col1 = 4'b0001 << c;
        #1;
        if (row1 != 4'b0000) begin
          hits++;
          fc = c;
          for (int r = 0; r < 4; r++) if (row1[r]) fr = r;
        end
      end
      col1 = 4'b0000;
      $display("scan key=%h hits=%0d row=%0d col=%0d decoded=%h", codes[i], hits, fr, fc, kmap[fr*4+fc]);
      chk($sformatf("scan_code_%h", codes[i]), {4'h0, kmap[fr*4+fc]}, {4'h0, codes[i]});
      chk($sformatf("scan_hits_%h", codes[i]), 8'(hits), 8'h01);
      repeat (27) step();
      chk($sformatf("scan_done_%h", codes[i]), {7'h0, done1}, 8'h01);
    end

    // 4: key A, mismatched column
    col1 = 4'b0001;
    h1.key_code = 4'hA; h1.key_valid = 1'b1;
    step();
    h1.key_valid = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      chk($sformatf("mis_row_k%0d", k), {4'h0, row1}, 8'h00);
      if (k >= 9 && k <= 28) chk($sformatf("mis_srow_k%0d", k), {7'h0, s_row1}, 8'h01);
      if (k < 42) step();
    end
    $display("mismatch key=A done=%b", done1);
    chk("mis_done", {7'h0, done1}, 8'h01);

    // 5: valid held through busy; second code only taken at done
    col1 = 4'b0010;
    h1.key_code = 4'h2; h1.key_valid = 1'b1;
    step();
    h1.key_code = 4'h7;
    for (int k = 1; k <= 42; k++) begin
      if (k < 42) chk($sformatf("hold_ready_k%0d", k), {7'h0, h1.key_ready}, 8'h00);
      if (k == 15) chk("hold_first_row", {4'h0, row1}, 8'h01);
      if (k < 42) step();
    end
    chk("hold_done", {7'h0, done1}, 8'h01);
    chk("hold_ready_at_done", {7'h0, h1.key_ready}, 8'h01);
    col1 = 4'b0001;
    step();
    h1.key_valid = 1'b0;
    $display("second press row=%b busy=%b", row1, busy1);
    chk("second_row", {4'h0, row1}, 8'h04);
    chk("second_busy", {7'h0, busy1}, 8'h01);
    repeat (41) step();
    chk("second_done", {7'h0, done1}, 8'h01);

    // 6: no-bounce instance, key F, async reset mid-hold
    col2 = 4'b0100;
    h2.key_code = 4'hF; h2.key_valid = 1'b1;
    step();
    h2.key_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("nb_row_k%0d", k), {4'h0, row2}, 8'h08);
      if (k < 10) step();
    end
    #2 rst_n = 1'b0;
    #1;
    $display("nb reset row=%b srow=%b busy=%b", row2, s_row2, busy2);
    chk("nb_rst_row", {4'h0, row2}, 8'h00);
    chk("nb_rst_srow", {7'h0, s_row2}, 8'h00);
    chk("nb_rst_busy", {7'h0, busy2}, 8'h00);
    step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      chk($sformatf("nb_nodone_%0d", k), {7'h0, done2}, 8'h00);
    end
    chk("nb_ready", {7'h0, h2.key_ready}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
